// File: rtl/insn_fetch_mem.sv
// insn_fetch_mem
// Instruction memory for the fetch port of the ooocpu core.
//
// A fetch is accepted when rd_insn_en && req_ready. Storage is read at
// acceptance. The instruction, its pc and an error tag then travel through a
// LATENCY-deep pipe and appear with a one-cycle insn_valid pulse LATENCY
// cycles later. The core cannot stall the output side.
//
// After each accept a throttle can force WAIT_CYCLES idle cycles (req_ready=0).
// The throttle is a two-state FSM (IDLE/WAIT).
// flush kills every in-flight fetch, but keeps a request accepted in the same
// cycle, because that request is the redirect target.
// A write port preloads or patches storage. A read of the word being written in
// the same cycle returns the old contents.
//
// Handshake: a request transfers on a rising clk edge where rd_insn_en and
// req_ready are both 1. pc must be stable while rd_insn_en is high. insn_valid
// has no ready partner, so results must be consumed in the cycle they appear.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   rd_insn_en, pc      fetch request and byte address
//   req_ready           request is accepted this cycle when rd_insn_en is high
//   flush               drop all in-flight fetches
//   insn, insn_pc       fetched word and its pc (held while insn_valid=0)
//   insn_valid          one-cycle pulse per returned fetch
//   addr_err            fetch was misaligned or outside storage (insn = NOP)
//   wr_en/addr/data     storage write, word indexed
//
// INIT_FILE names an optional hex image. That image is loaded by the
// simulation environment, so this synthesizable body never reads it.
module insn_fetch_mem #(
    parameter int                    WORD_WIDTH  = 32,
    parameter int                    PC_WIDTH    = 32,
    parameter int                    DEPTH       = 1024,
    parameter int                    LATENCY     = 1,
    parameter int                    WAIT_CYCLES = 0,
    parameter logic [PC_WIDTH-1:0]   BASE_ADDR   = '0,
    parameter string                 INIT_FILE   = ""
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rd_insn_en,
    input  logic [PC_WIDTH-1:0]        pc,
    output logic                       req_ready,
    input  logic                       flush,
    output logic [WORD_WIDTH-1:0]      insn,
    output logic [PC_WIDTH-1:0]        insn_pc,
    output logic                       insn_valid,
    output logic                       addr_err,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [WORD_WIDTH-1:0]      wr_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [WORD_WIDTH-1:0] NOP_INSN = WORD_WIDTH'(32'h0000_0013);
    localparam logic [3:0]            WAIT_LD  = 4'(WAIT_CYCLES);

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    // Storage. It is not reset.
    logic [WORD_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Address decode
    logic [PC_WIDTH-1:0]   offset;
    logic [PC_WIDTH-1:0]   word_idx;
    logic                  fetch_err;
    logic [WORD_WIDTH-1:0] rd_word;

    assign offset    = pc - BASE_ADDR;
    assign word_idx  = offset >> 2;
    assign fetch_err = (pc[1:0] != 2'b00) || (pc < BASE_ADDR) ||
                       (word_idx >= PC_WIDTH'(DEPTH));
    // This read happens before the write at the same edge, so the old word is returned.
    assign rd_word   = mem_q[word_idx[AW-1:0]];

    // Throttle FSM
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       accept;

    assign accept = rd_insn_en && req_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = (state_q == ST_IDLE);
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && (WAIT_LD != 4'd0)) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LD;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Return pipe. A stage's payload moves only together with a live valid.
    // As a result, the last stage keeps the most recent result while insn_valid is low.
    logic                  vld_q [LATENCY];
    logic [PC_WIDTH-1:0]   pc_q  [LATENCY];
    logic [WORD_WIDTH-1:0] dat_q [LATENCY];
    logic                  err_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                pc_q[i]  <= '0;
                dat_q[i] <= '0;
                err_q[i] <= 1'b0;
            end
        end else begin
            // Stage 0 takes the new accept even during flush, because that accept is the redirect.
            vld_q[0] <= accept;
            if (accept) begin
                pc_q[0]  <= pc;
                dat_q[0] <= fetch_err ? NOP_INSN : rd_word;
                err_q[0] <= fetch_err;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1] && !flush;
                if (vld_q[i-1] && !flush) begin
                    pc_q[i]  <= pc_q[i-1];
                    dat_q[i] <= dat_q[i-1];
                    err_q[i] <= err_q[i-1];
                end
            end
        end
    end

    assign insn_valid = vld_q[LATENCY-1];
    assign insn       = dat_q[LATENCY-1];
    assign insn_pc    = pc_q[LATENCY-1];
    assign addr_err   = err_q[LATENCY-1];

endmodule

// File: tb/tb_insn_fetch_mem.sv
// Bench for insn_fetch_mem. It drives three configurations from one shared
// request/write bus:
//   d0: LATENCY=1, WAIT_CYCLES=0
//   d1: LATENCY=3, WAIT_CYCLES=2
//   d2: LATENCY=3, WAIT_CYCLES=0
// The reference model is transaction level. It tracks, for each config, the
// earliest cycle a request may be accepted, and a list of fetches tagged with
// the cycle they are due back. It also keeps a plain array for storage.
module tb_insn_fetch_mem;

    localparam int DEPTH = 64;
    localparam int ND    = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_insn_en;
    logic [31:0] pc;
    logic        flush;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;

    logic        rdy_w [ND];
    logic [31:0] ins_w [ND];
    logic [31:0] ipc_w [ND];
    logic        vld_w [ND];
    logic        err_w [ND];

    always #5 clk = ~clk;

    insn_fetch_mem #(.DEPTH(DEPTH), .LATENCY(1), .WAIT_CYCLES(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .rd_insn_en(rd_insn_en), .pc(pc),
        .req_ready(rdy_w[0]), .flush(flush), .insn(ins_w[0]), .insn_pc(ipc_w[0]),
        .insn_valid(vld_w[0]), .addr_err(err_w[0]), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data));

    insn_fetch_mem #(.DEPTH(DEPTH), .LATENCY(3), .WAIT_CYCLES(2)) u_d1 (
        .clk(clk), .rst_n(rst_n), .rd_insn_en(rd_insn_en), .pc(pc),
        .req_ready(rdy_w[1]), .flush(flush), .insn(ins_w[1]), .insn_pc(ipc_w[1]),
        .insn_valid(vld_w[1]), .addr_err(err_w[1]), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data));

    insn_fetch_mem #(.DEPTH(DEPTH), .LATENCY(3), .WAIT_CYCLES(0)) u_d2 (
        .clk(clk), .rst_n(rst_n), .rd_insn_en(rd_insn_en), .pc(pc),
        .req_ready(rdy_w[2]), .flush(flush), .insn(ins_w[2]), .insn_pc(ipc_w[2]),
        .insn_valid(vld_w[2]), .addr_err(err_w[2]), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data));

    // Reference model state
    typedef struct {
        int          k;
        int          due;
        logic [31:0] pc;
        logic [31:0] data;
        logic        err;
    } ent_t;

    int          lat_t [ND] = '{1, 3, 3};
    int          wt_t  [ND] = '{0, 2, 0};
    int          nxt   [ND];
    logic [31:0] h_ins [ND];
    logic [31:0] h_pc  [ND];
    logic        h_err [ND];
    logic [31:0] mem_m [DEPTH];
    ent_t        exp_q [$];
    int          cyc;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        for (int k = 0; k < ND; k++) begin
            nxt[k]   = 0;
            h_ins[k] = '0;
            h_pc[k]  = '0;
            h_err[k] = 1'b0;
        end
    endtask

    // Effect of the edge that ends cycle cyc. Fetches read storage before the write lands.
    task automatic model_edge(input bit req, input logic [31:0] a, input bit fl,
                              input bit we, input logic [5:0] wa, input logic [31:0] wd);
        logic [31:0] wi;
        bit          bad;
        bit          acc;
        wi  = a >> 2;
        bad = (a[1:0] != 2'b00) || (wi >= DEPTH);
        for (int k = 0; k < ND; k++) begin
            acc = req && (cyc >= nxt[k]);
            if (fl) begin
                for (int i = exp_q.size() - 1; i >= 0; i--) begin
                    if (exp_q[i].k == k && exp_q[i].due > cyc) exp_q.delete(i);
                end
            end
            if (acc) begin
                exp_q.push_back('{k: k, due: cyc + lat_t[k], pc: a,
                                  data: bad ? 32'h0000_0013 : mem_m[wi[5:0]], err: bad});
            end
            if (fl) nxt[k] = cyc + 1;
            else if (acc) nxt[k] = cyc + wt_t[k] + 1;
        end
        if (we) mem_m[wa] = wd;
    endtask

    task automatic check_outputs();
        bit exp_v;
        for (int k = 0; k < ND; k++) begin
            exp_v = 1'b0;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i].k == k && exp_q[i].due == cyc) begin
                    exp_v    = 1'b1;
                    h_ins[k] = exp_q[i].data;
                    h_pc[k]  = exp_q[i].pc;
                    h_err[k] = exp_q[i].err;
                    exp_q.delete(i);
                    break;
                end
            end
            check($sformatf("d%0d req_ready", k), 32'(rdy_w[k]), 32'(cyc >= nxt[k]));
            check($sformatf("d%0d insn_valid", k), 32'(vld_w[k]), 32'(exp_v));
            check($sformatf("d%0d insn", k), ins_w[k], h_ins[k]);
            check($sformatf("d%0d insn_pc", k), ipc_w[k], h_pc[k]);
            check($sformatf("d%0d addr_err", k), 32'(err_w[k]), 32'(h_err[k]));
        end
    endtask

    task automatic cycle(input bit req, input logic [31:0] a, input bit fl,
                         input bit we, input logic [5:0] wa, input logic [31:0] wd);
        rd_insn_en = req;
        pc         = a;
        flush      = fl;
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        model_edge(req, a, fl, we, wa, wd);
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] a);
        cycle(1'b1, a, 1'b0, 1'b0, 6'd0, 32'h0);
    endtask

    task automatic check_reset_values(input string tag);
        for (int k = 0; k < ND; k++) begin
            check($sformatf("%s d%0d insn", tag, k), ins_w[k], 32'h0);
            check($sformatf("%s d%0d insn_pc", k == 0 ? tag : tag, k), ipc_w[k], 32'h0);
            check($sformatf("%s d%0d valid", tag, k), 32'(vld_w[k]), 32'h0);
            check($sformatf("%s d%0d addr_err", tag, k), 32'(err_w[k]), 32'h0);
            check($sformatf("%s d%0d req_ready", tag, k), 32'(rdy_w[k]), 32'h1);
        end
    endtask

    // Asynchronous reset asserted mid-cycle for one clock.
    task automatic do_reset();
        rd_insn_en = 1'b0;
        flush      = 1'b0;
        wr_en      = 1'b0;
        rst_n      = 1'b0;
        #2;
        model_clear();
        check_reset_values("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
        check_outputs();
    endtask

    initial begin
        logic [31:0] old5;
        logic [31:0] a;
        logic [31:0] r;
        bit          we;
        logic [5:0]  wa;

        rst_n      = 1'b0;
        rd_insn_en = 1'b0;
        pc         = '0;
        flush      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        cyc        = 0;
        model_clear();
        #3;
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Preload storage through the write port
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b0, 32'h0, 1'b0, 1'b1, 6'(i), $urandom);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 32'h0, 1'b0, 1'b1, 6'(i), 32'hA000_0000 + 32'(i));

        // Back-to-back word fetches 0,4,8,C
        for (int i = 0; i < 4; i++) fetch(32'(4 * i));
        idle(4);

        // rd_insn_en held high with pc stepping: throttled 1,0,0,1 on d1
        for (int i = 0; i < 9; i++) fetch(32'h20 + 32'(4 * i));
        idle(4);

        // Error cases: misaligned, then just past the end of storage
        fetch(32'h2);
        check("misaligned nop", ins_w[0], 32'h0000_0013);
        check("misaligned err", 32'(err_w[0]), 32'h1);
        fetch(32'(4 * DEPTH));
        check("out_of_range nop", ins_w[0], 32'h0000_0013);
        check("out_of_range err", 32'(err_w[0]), 32'h1);
        idle(4);

        // Two fetches in flight, then flush with redirect to 0x40
        fetch(32'h10);
        fetch(32'h14);
        cycle(1'b1, 32'h40, 1'b1, 1'b0, 6'd0, 32'h0);
        idle(5);

        // Same-cycle write and read of index 5 returns the old word
        old5 = mem_m[5];
        cycle(1'b1, 32'h14, 1'b0, 1'b1, 6'd5, 32'hDEAD_BEEF);
        check("rbw old word", ins_w[0], old5);
        fetch(32'h14);
        check("rbw new word", ins_w[0], 32'hDEAD_BEEF);
        idle(4);

        // Reset with fetches in flight
        fetch(32'h0);
        fetch(32'h4);
        do_reset();
        idle(5);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 15);
            if (r == 0)      a = (32'($urandom_range(0, DEPTH - 1)) << 2) + 32'($urandom_range(1, 3));
            else if (r == 1) a = 32'(4 * DEPTH) + (32'($urandom_range(0, 255)) << 2);
            else             a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            we = ($urandom_range(0, 3) == 0);
            wa = ($urandom_range(0, 3) == 0) ? a[7:2] : 6'($urandom_range(0, DEPTH - 1));
            cycle($urandom_range(0, 3) != 0, a, $urandom_range(0, 15) == 0, we, wa, $urandom);
        end
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
